// File: rtl/boot_loader.sv
// Streams a byte image into main memory as little-endian LINE_W-bit lines starting at
// BASE_LINE, keeping the CPU in reset until the final line has been committed.
module boot_loader #(
  parameter int LINE_W    = 128,
  parameter int ADDR_W    = 12,
  parameter int BASE_LINE = 2048,
  parameter int MAX_LINES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W-1:0] lines_written_o
);

  localparam int LINE_BYTES = LINE_W / 8;
  localparam int BC_W       = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam int CNT_W      = $clog2(MAX_LINES + 1);

  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(LINE_BYTES - 1);
  localparam logic [CNT_W-1:0]  MAX_IDX   = CNT_W'(MAX_LINES);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_LINE);

  typedef enum logic [1:0] {S_FILL, S_WRITE, S_DONE, S_ERROR} state_e;

  state_e            state_q;
  logic [BC_W-1:0]   byte_cnt_q;
  logic [LINE_W-1:0] buf_q;
  logic [CNT_W-1:0]  line_idx_q;
  logic              last_seen_q;
  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              cpu_rst_q;
  logic              done_q;
  logic              error_q;
  logic [ADDR_W-1:0] lines_written_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= S_FILL;
      byte_cnt_q      <= '0;
      buf_q           <= '0;
      line_idx_q      <= '0;
      last_seen_q     <= 1'b0;
      in_ready_q      <= 1'b1;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      cpu_rst_q       <= 1'b1;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      lines_written_q <= '0;
    end else begin
      case (state_q)
        S_FILL: begin
          // in_ready is always high in FILL, so a valid byte is an accepted byte
          if (in_valid_i) begin
            buf_q[{byte_cnt_q, 3'b000} +: 8] <= in_data_i;
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (in_last_i) begin
              last_seen_q <= 1'b1;
            end
            if ((byte_cnt_q == LAST_BYTE) || in_last_i) begin
              in_ready_q <= 1'b0;
              if (line_idx_q == MAX_IDX) begin
                state_q <= S_ERROR;
                error_q <= 1'b1;
              end else begin
                state_q    <= S_WRITE;
                mem_we_q   <= 1'b1;
                mem_addr_q <= BASE_ADDR + ADDR_W'(line_idx_q);
              end
            end
          end
        end
        S_WRITE: begin
          if (mem_ready_i) begin
            mem_we_q        <= 1'b0;
            line_idx_q      <= line_idx_q + 1'b1;
            lines_written_q <= lines_written_q + 1'b1;
            byte_cnt_q      <= '0;
            buf_q           <= '0;
            if (last_seen_q) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q    <= S_FILL;
              in_ready_q <= 1'b1;
            end
          end
        end
        S_DONE, S_ERROR: begin
          state_q <= state_q;
        end
        default: begin
          // an illegal encoding is treated as a failed load, keeping the CPU held
          state_q    <= S_ERROR;
          in_ready_q <= 1'b0;
          mem_we_q   <= 1'b0;
          cpu_rst_q  <= 1'b1;
          done_q     <= 1'b0;
          error_q    <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o      = in_ready_q;
  assign mem_we_o        = mem_we_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_wdata_o     = buf_q;
  assign cpu_rst_o       = cpu_rst_q;
  assign done_o          = done_q;
  assign error_o         = error_q;
  assign lines_written_o = lines_written_q;

endmodule
